// File: rtl/sram_port_arbiter.sv
// Two-requester front end for a single sram with one write and one registered read port.
// Write and read ports are arbitrated independently with round-robin priority on contention.
module sram_port_arbiter #(
    parameter int DWIDTH = 56,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    input  logic              a_req_we,
    input  logic [AWIDTH-1:0] a_req_addr,
    input  logic [DWIDTH-1:0] a_req_wdata,
    output logic              a_req_ready,
    output logic              a_rsp_valid,
    output logic [DWIDTH-1:0] a_rsp_data,

    input  logic              b_req_valid,
    input  logic              b_req_we,
    input  logic [AWIDTH-1:0] b_req_addr,
    input  logic [DWIDTH-1:0] b_req_wdata,
    output logic              b_req_ready,
    output logic              b_rsp_valid,
    output logic [DWIDTH-1:0] b_rsp_data,

    output logic              sram_we,
    output logic [AWIDTH-1:0] sram_addr_w,
    output logic [DWIDTH-1:0] sram_data_i,
    output logic [AWIDTH-1:0] sram_addr_r,
    input  logic [DWIDTH-1:0] sram_data_o
);

    logic       wr_prio;
    logic       rd_prio;
    logic [1:0] rsp_sel;

    logic a_wr_cand, b_wr_cand, a_rd_cand, b_rd_cand;
    logic a_wr_grant, b_wr_grant, a_rd_grant, b_rd_grant;
    logic wr_contest, rd_contest;

    // Candidates are masked by rst so no grant, ready or sram write can escape a reset cycle.
    always_comb begin
        a_wr_cand  = a_req_valid &  a_req_we & ~rst;
        b_wr_cand  = b_req_valid &  b_req_we & ~rst;
        a_rd_cand  = a_req_valid & ~a_req_we & ~rst;
        b_rd_cand  = b_req_valid & ~b_req_we & ~rst;

        wr_contest = a_wr_cand & b_wr_cand;
        rd_contest = a_rd_cand & b_rd_cand;

        a_wr_grant = a_wr_cand & (~b_wr_cand | ~wr_prio);
        b_wr_grant = b_wr_cand & (~a_wr_cand |  wr_prio);
        a_rd_grant = a_rd_cand & (~b_rd_cand | ~rd_prio);
        b_rd_grant = b_rd_cand & (~a_rd_cand |  rd_prio);
    end

    // On contention the winner is the favoured side, so flipping the bit points it at the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prio <= 1'b0;
            rd_prio <= 1'b0;
            rsp_sel <= '0;
        end else begin
            if (wr_contest) wr_prio <= ~wr_prio;
            if (rd_contest) rd_prio <= ~rd_prio;
            rsp_sel <= {b_rd_grant, a_rd_grant};
        end
    end

    always_comb begin
        a_req_ready = a_wr_grant | a_rd_grant;
        b_req_ready = b_wr_grant | b_rd_grant;

        sram_we     = a_wr_grant | b_wr_grant;
        sram_addr_w = '0;
        sram_data_i = '0;
        if (a_wr_grant) begin
            sram_addr_w = a_req_addr;
            sram_data_i = a_req_wdata;
        end else if (b_wr_grant) begin
            sram_addr_w = b_req_addr;
            sram_data_i = b_req_wdata;
        end

        sram_addr_r = '0;
        if (a_rd_grant)      sram_addr_r = a_req_addr;
        else if (b_rd_grant) sram_addr_r = b_req_addr;
    end

    // Responses are squashed while rst is high, which also drops a read granted just before reset.
    always_comb begin
        a_rsp_valid = rsp_sel[0] & ~rst;
        b_rsp_valid = rsp_sel[1] & ~rst;
        a_rsp_data  = a_rsp_valid ? sram_data_o : '0;
        b_rsp_data  = b_rsp_valid ? sram_data_o : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: sram model, per-cycle reference model comparison, and
// directed scenarios with literal expectations.
module tb_sram_port_arbiter;

    localparam int DW = 56;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          a_req_valid, a_req_we, a_req_ready, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_data;
    logic          b_req_valid, b_req_we, b_req_ready, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_data;
    logic          sram_we;
    logic [AW-1:0] sram_addr_w, sram_addr_r;
    logic [DW-1:0] sram_data_i, sram_data_o;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
        .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
        .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .sram_we(sram_we), .sram_addr_w(sram_addr_w), .sram_data_i(sram_data_i),
        .sram_addr_r(sram_addr_r), .sram_data_o(sram_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-before-write sram with registered read data.
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            sram_data_o <= mem[sram_addr_r];
            if (sram_we) mem[sram_addr_w] <= sram_data_i;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: favoured-side indices, the pending response owner and an image of memory.
    initial begin : model
        logic [DW-1:0] ref_mem [256];
        int wr_fav, rd_fav, rsp_who;
        logic [DW-1:0] rsp_val;
        int wwin, rwin;
        bit wc [2];
        bit rc [2];
        logic [AW-1:0] addr [2];
        logic [DW-1:0] wdat [2];
        logic [DW-1:0] exp_aw, exp_ar, exp_di;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        wr_fav = 0; rd_fav = 0; rsp_who = -1; rsp_val = '0;
        forever begin
            @(negedge clk);
            wc[0] = a_req_valid && a_req_we;   rc[0] = a_req_valid && !a_req_we;
            wc[1] = b_req_valid && b_req_we;   rc[1] = b_req_valid && !b_req_we;
            addr[0] = a_req_addr; addr[1] = b_req_addr;
            wdat[0] = a_req_wdata; wdat[1] = b_req_wdata;

            wwin = -1; rwin = -1;
            if (!rst) begin
                if (wc[0] && wc[1]) wwin = wr_fav;
                else if (wc[0])     wwin = 0;
                else if (wc[1])     wwin = 1;
                if (rc[0] && rc[1]) rwin = rd_fav;
                else if (rc[0])     rwin = 0;
                else if (rc[1])     rwin = 1;
            end
            exp_aw = (wwin >= 0) ? {{(DW-AW){1'b0}}, addr[wwin]} : '0;
            exp_di = (wwin >= 0) ? wdat[wwin] : '0;
            exp_ar = (rwin >= 0) ? {{(DW-AW){1'b0}}, addr[rwin]} : '0;

            chk("a_req_ready", 64'(a_req_ready), 64'(!rst && (wwin == 0 || rwin == 0)));
            chk("b_req_ready", 64'(b_req_ready), 64'(!rst && (wwin == 1 || rwin == 1)));
            chk("sram_we",     64'(sram_we),     64'(wwin >= 0));
            chk("sram_addr_w", 64'(sram_addr_w), 64'(exp_aw));
            chk("sram_data_i", 64'(sram_data_i), 64'(exp_di));
            chk("sram_addr_r", 64'(sram_addr_r), 64'(exp_ar));
            chk("a_rsp_valid", 64'(a_rsp_valid), 64'(!rst && rsp_who == 0));
            chk("b_rsp_valid", 64'(b_rsp_valid), 64'(!rst && rsp_who == 1));
            chk("a_rsp_data",  64'(a_rsp_data),  (!rst && rsp_who == 0) ? 64'(rsp_val) : 64'd0);
            chk("b_rsp_data",  64'(b_rsp_data),  (!rst && rsp_who == 1) ? 64'(rsp_val) : 64'd0);

            if (rst) begin
                wr_fav = 0; rd_fav = 0; rsp_who = -1;
            end else begin
                if (wc[0] && wc[1]) wr_fav = 1 - wwin;
                if (rc[0] && rc[1]) rd_fav = 1 - rwin;
                rsp_who = rwin;
                if (rwin >= 0) rsp_val = ref_mem[addr[rwin]];
                if (wwin >= 0) ref_mem[addr[wwin]] = wdat[wwin];
            end
        end
    end

    // Applies one cycle of inputs just after posedge and returns mid-cycle for literal checks.
    task automatic cyc(input logic r,
                       input logic av, input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        @(posedge clk);
        #2;
        rst = r;
        a_req_valid = av; a_req_we = awe; a_req_addr = aa; a_req_wdata = ad;
        b_req_valid = bv; b_req_we = bwe; b_req_addr = ba; b_req_wdata = bd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 56'h0, 1'b0, 1'b0, 8'h00, 56'h0);
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;

        // Reset held with all requests active
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 8'h10, 56'h55, 1'b1, 1'b0, 8'h10, 56'h0);
            chk("lit_rst_a_ready", 64'(a_req_ready), 64'd0);
            chk("lit_rst_b_ready", 64'(b_req_ready), 64'd0);
            chk("lit_rst_we",      64'(sram_we),     64'd0);
            chk("lit_rst_a_rsp",   64'(a_rsp_valid), 64'd0);
        end

        // Single write then read-back by A
        cyc(1'b0, 1'b1, 1'b1, 8'h10, 56'h1234, 1'b0, 1'b0, 8'h00, 56'h0);
        chk("lit_wr_a_ready", 64'(a_req_ready), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 56'h0, 1'b0, 1'b0, 8'h00, 56'h0);
        chk("lit_rd_a_ready", 64'(a_req_ready), 64'd1);
        idle();
        chk("lit_rd_a_valid", 64'(a_rsp_valid), 64'd1);
        chk("lit_rd_a_data",  64'(a_rsp_data),  64'h1234);
        chk("lit_rd_b_valid", 64'(b_rsp_valid), 64'd0);

        // Contested writes from reset alternate A then B
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 56'h0, 1'b0, 1'b0, 8'h00, 56'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'h05, 56'h11, 1'b1, 1'b1, 8'h05, 56'h22);
            chk("lit_cw_a_ready", 64'(a_req_ready), (i == 0) ? 64'd1 : 64'd0);
            chk("lit_cw_b_ready", 64'(b_req_ready), (i == 0) ? 64'd0 : 64'd1);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h05, 56'h0, 1'b0, 1'b0, 8'h00, 56'h0);
        idle();
        chk("lit_cw_data", 64'(a_rsp_data), 64'h22);

        // Same-address read and write in one cycle returns old data
        cyc(1'b0, 1'b1, 1'b1, 8'h20, 56'hAA, 1'b0, 1'b0, 8'h00, 56'h0);
        cyc(1'b0, 1'b1, 1'b1, 8'h20, 56'hBB, 1'b1, 1'b0, 8'h20, 56'h0);
        chk("lit_rw_a_ready", 64'(a_req_ready), 64'd1);
        chk("lit_rw_b_ready", 64'(b_req_ready), 64'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 56'h0, 1'b1, 1'b0, 8'h20, 56'h0);
        chk("lit_rw_old", 64'(b_rsp_data), 64'hAA);
        idle();
        chk("lit_rw_new", 64'(b_rsp_data), 64'hBB);

        // Preload 1..4, then contested back-to-back reads
        for (int i = 1; i <= 4; i++)
            cyc(1'b0, 1'b1, 1'b1, AW'(i), DW'(32'h100 + i), 1'b0, 1'b0, 8'h00, 56'h0);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) cyc(1'b0, 1'b1, 1'b0, AW'(i), 56'h0, 1'b1, 1'b0, AW'(i), 56'h0);
            else        idle();
            if (i <= 4) begin
                chk("lit_rr_a_ready", 64'(a_req_ready), 64'(i % 2));
                chk("lit_rr_b_ready", 64'(b_req_ready), 64'(1 - i % 2));
            end
            if (i >= 2) begin
                chk("lit_rr_a_valid", 64'(a_rsp_valid), 64'((i - 1) % 2));
                chk("lit_rr_b_valid", 64'(b_rsp_valid), 64'(i % 2));
                chk("lit_rr_data", (i % 2 == 0) ? 64'(a_rsp_data) : 64'(b_rsp_data), 64'(32'h100 + i - 1));
            end
        end

        // Full-range address
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 56'h0, 1'b1, 1'b1, 8'hFF, 56'hFF_FFFF_FFFF_FFFF);
        cyc(1'b0, 1'b1, 1'b0, 8'hFF, 56'h0, 1'b0, 1'b0, 8'h00, 56'h0);
        idle();
        chk("lit_top_addr", 64'(a_rsp_data), 64'h00FF_FFFF_FFFF_FFFF);

        // Leave wr_prio B-favoured, then a read followed by reset mid-operation
        cyc(1'b0, 1'b1, 1'b1, 8'h30, 56'h7, 1'b1, 1'b1, 8'h31, 56'h8);
        chk("lit_pre_a_ready", 64'(a_req_ready), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 56'h0, 1'b0, 1'b0, 8'h00, 56'h0);
        chk("lit_pre_rd_ready", 64'(a_req_ready), 64'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'h10, 56'h0, 1'b1, 1'b1, 8'h10, 56'hDEAD);
        chk("lit_mid_rst_valid", 64'(a_rsp_valid), 64'd0);
        chk("lit_mid_rst_we",    64'(sram_we),     64'd0);
        idle();
        chk("lit_post_rst_valid", 64'(a_rsp_valid), 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 8'h40, 56'h1, 1'b1, 1'b1, 8'h41, 56'h2);
        chk("lit_post_rst_a_fav", 64'(a_req_ready), 64'd1);
        chk("lit_post_rst_b",     64'(b_req_ready), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 56'h0, 1'b1, 1'b0, 8'h10, 56'h0);
        idle();
        chk("lit_rst_write_dropped", 64'(b_rsp_data), 64'h1234);

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
